// File: rtl/io_port_controller.sv
// ---------------------------------------------------------------------------
// io_port_controller
//
// Peripheral-side endpoint of the processor's 16-bit IN/OUT ports. It sits
// beside Processor at top level.
//
// The host offers words over a valid/ready handshake. Those words are queued
// in an input FIFO, and the head word is presented on In_Port. The processor
// pops the head by pulsing in_read when it executes IN.
//
// Every processor OUT write (Out_Port + out_write) is captured in an output
// FIFO. The host drains that FIFO over a valid/ready handshake.
//
// Ports:
//   clk            - system clock, all state updates on rising edge
//   reset          - synchronous active-high; flushes both FIFOs, clears flags
//   host_in_data   - word offered by the host
//   host_in_valid  - host word valid
//   host_in_ready  - input FIFO can accept a word this cycle
//   In_Port        - head of input FIFO, 0 when empty
//   in_read        - processor executed IN, pop input head
//   in_empty       - input FIFO empty
//   Out_Port       - processor OUT data
//   out_write      - processor executed OUT, capture Out_Port
//   out_full       - output FIFO full
//   host_out_data  - head of output FIFO, 0 when empty
//   host_out_valid - output FIFO non-empty
//   host_out_ready - host consumes the output head this cycle
//   in_underflow   - sticky: in_read seen while input FIFO empty
//   out_overflow   - sticky: out_write dropped while output FIFO full
//   clear_flags    - synchronous clear of both sticky flags
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module io_port_controller #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] In_Port,
  input  logic              in_read,
  output logic              in_empty,
  input  logic [DATA_W-1:0] Out_Port,
  input  logic              out_write,
  output logic              out_full,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              in_underflow,
  output logic              out_overflow,
  input  logic              clear_flags
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL_CNT  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL_CNT = (OUT_AW+1)'(OUT_DEPTH);

  logic [DATA_W-1:0] r_inMem [IN_DEPTH];
  logic [IN_AW-1:0]  r_inRdPtr;
  logic [IN_AW-1:0]  r_inWrPtr;
  logic [IN_AW:0]    r_inCount;

  logic [DATA_W-1:0] r_outMem [OUT_DEPTH];
  logic [OUT_AW-1:0] r_outRdPtr;
  logic [OUT_AW-1:0] r_outWrPtr;
  logic [OUT_AW:0]   r_outCount;

  logic r_inUnderflow;
  logic r_outOverflow;

  logic w_inEmpty;
  logic w_inFull;
  logic w_inPush;
  logic w_inPop;
  logic w_inUnderSet;
  logic w_outEmpty;
  logic w_outFull;
  logic w_outPush;
  logic w_outPop;
  logic w_outOverSet;

  // Status decode and handshake qualification.
  // host_in_ready ignores a same-cycle pop, so the host never writes into a
  // full input FIFO. The output side does accept a write into a full FIFO
  // when the host pops in the same cycle, because the processor cannot stall
  // on OUT.
  assign w_inEmpty    = (r_inCount == '0);
  assign w_inFull     = (r_inCount == IN_FULL_CNT);
  assign w_inPush     = host_in_valid & ~w_inFull;
  assign w_inPop      = in_read & ~w_inEmpty;
  assign w_inUnderSet = in_read & w_inEmpty;

  assign w_outEmpty   = (r_outCount == '0);
  assign w_outFull    = (r_outCount == OUT_FULL_CNT);
  assign w_outPop     = host_out_ready & ~w_outEmpty;
  assign w_outPush    = out_write & (~w_outFull | w_outPop);
  assign w_outOverSet = out_write & w_outFull & ~w_outPop;

  assign host_in_ready  = ~w_inFull;
  assign in_empty       = w_inEmpty;
  assign In_Port        = w_inEmpty ? '0 : r_inMem[r_inRdPtr];
  assign out_full       = w_outFull;
  assign host_out_valid = ~w_outEmpty;
  assign host_out_data  = w_outEmpty ? '0 : r_outMem[r_outRdPtr];
  assign in_underflow   = r_inUnderflow;
  assign out_overflow   = r_outOverflow;

  // Storage arrays need no reset. A flushed FIFO hides its stale contents
  // because both data outputs are forced to 0 while the count is 0.
  always_ff @(posedge clk) begin
    if (!reset && w_inPush) begin
      r_inMem[r_inWrPtr] <= host_in_data;
    end
    if (!reset && w_outPush) begin
      r_outMem[r_outWrPtr] <= Out_Port;
    end
  end

  // Input FIFO pointers and occupancy. A push and a pop in the same cycle
  // advance both pointers and leave the count unchanged. A pop against an
  // empty FIFO is already masked out of w_inPop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inRdPtr <= '0;
      r_inWrPtr <= '0;
      r_inCount <= '0;
    end else begin
      if (w_inPush) begin
        r_inWrPtr <= r_inWrPtr + 1'b1;
      end
      if (w_inPop) begin
        r_inRdPtr <= r_inRdPtr + 1'b1;
      end
      case ({w_inPush, w_inPop})
        2'b10:   r_inCount <= r_inCount + 1'b1;
        2'b01:   r_inCount <= r_inCount - 1'b1;
        default: r_inCount <= r_inCount;
      endcase
    end
  end

  // Output FIFO pointers and occupancy. A write into a full FIFO during a
  // host pop lands in the slot the pop frees, so the count stays at the
  // full value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outRdPtr <= '0;
      r_outWrPtr <= '0;
      r_outCount <= '0;
    end else begin
      if (w_outPush) begin
        r_outWrPtr <= r_outWrPtr + 1'b1;
      end
      if (w_outPop) begin
        r_outRdPtr <= r_outRdPtr + 1'b1;
      end
      case ({w_outPush, w_outPop})
        2'b10:   r_outCount <= r_outCount + 1'b1;
        2'b01:   r_outCount <= r_outCount - 1'b1;
        default: r_outCount <= r_outCount;
      endcase
    end
  end

  // Sticky error flags. A set event in the same cycle as clear_flags wins,
  // so an error is never lost to a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inUnderflow <= 1'b0;
      r_outOverflow <= 1'b0;
    end else begin
      if (w_inUnderSet) begin
        r_inUnderflow <= 1'b1;
      end else if (clear_flags) begin
        r_inUnderflow <= 1'b0;
      end
      if (w_outOverSet) begin
        r_outOverflow <= 1'b1;
      end else if (clear_flags) begin
        r_outOverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
module tb_io_port_controller;

  localparam int DW        = 16;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] hostInData;
  logic          hostInValid;
  logic          hostInReady;
  logic [DW-1:0] inPort;
  logic          inRead;
  logic          inEmpty;
  logic [DW-1:0] outPort;
  logic          outWrite;
  logic          outFull;
  logic [DW-1:0] hostOutData;
  logic          hostOutValid;
  logic          hostOutReady;
  logic          inUnderflow;
  logic          outOverflow;
  logic          clearFlags;

  int nVectors;
  int nMiscompares;

  // Reference model: plain queues plus two flags, updated once per clock.
  logic [DW-1:0] mInQ[$];
  logic [DW-1:0] mOutQ[$];
  logic          mUnder;
  logic          mOver;

  // One directed vector holds the inputs for one clock and the outputs
  // expected just after that clock.
  typedef struct {
    logic          rst;
    logic [DW-1:0] hd;
    logic          hv;
    logic          rd;
    logic [DW-1:0] op;
    logic          ow;
    logic          hr;
    logic          clr;
    logic [DW-1:0] eInPort;
    logic          eInEmpty;
    logic          eInReady;
    logic [DW-1:0] eOutData;
    logic          eOutValid;
    logic          eOutFull;
    logic          eUnder;
    logic          eOver;
  } vec_t;

  vec_t vecs[15];

  io_port_controller #(
    .DATA_W(DW), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_in_data  (hostInData),
    .host_in_valid (hostInValid),
    .host_in_ready (hostInReady),
    .In_Port       (inPort),
    .in_read       (inRead),
    .in_empty      (inEmpty),
    .Out_Port      (outPort),
    .out_write     (outWrite),
    .out_full      (outFull),
    .host_out_data (hostOutData),
    .host_out_valid(hostOutValid),
    .host_out_ready(hostOutReady),
    .in_underflow  (inUnderflow),
    .out_overflow  (outOverflow),
    .clear_flags   (clearFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the rules for FIFO handshakes,
  // drop-on-full and set-wins sticky flags.
  task automatic modelStep(input logic rst, input logic [DW-1:0] hd, input logic hv,
                           input logic rd, input logic [DW-1:0] op, input logic ow,
                           input logic hr, input logic clr);
    bit inPush, inPop, underSet, outPop, outPush, overSet;
    if (rst) begin
      mInQ.delete();
      mOutQ.delete();
      mUnder = 1'b0;
      mOver  = 1'b0;
    end else begin
      inPush   = hv && (mInQ.size() < IN_DEPTH);
      inPop    = rd && (mInQ.size() > 0);
      underSet = rd && (mInQ.size() == 0);
      outPop   = hr && (mOutQ.size() > 0);
      outPush  = ow && ((mOutQ.size() < OUT_DEPTH) || outPop);
      overSet  = ow && (mOutQ.size() == OUT_DEPTH) && !outPop;
      if (inPop)   void'(mInQ.pop_front());
      if (inPush)  mInQ.push_back(hd);
      if (outPop)  void'(mOutQ.pop_front());
      if (outPush) mOutQ.push_back(op);
      if (underSet)   mUnder = 1'b1;
      else if (clr)   mUnder = 1'b0;
      if (overSet)    mOver = 1'b1;
      else if (clr)   mOver = 1'b0;
    end
  endtask

  // Drive one clock of inputs, advance the model and step past the edge.
  task automatic applyStimulus(input logic rst, input logic [DW-1:0] hd, input logic hv,
                               input logic rd, input logic [DW-1:0] op, input logic ow,
                               input logic hr, input logic clr);
    reset        = rst;
    hostInData   = hd;
    hostInValid  = hv;
    inRead       = rd;
    outPort      = op;
    outWrite     = ow;
    hostOutReady = hr;
    clearFlags   = clr;
    modelStep(rst, hd, hv, rd, op, ow, hr, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] eInPort,
                             input logic eInEmpty, input logic eInReady,
                             input logic [DW-1:0] eOutData, input logic eOutValid,
                             input logic eOutFull, input logic eUnder, input logic eOver);
    logic [2*DW+5:0] act, exp;
    act = {inPort, inEmpty, hostInReady, hostOutData, hostOutValid, outFull, inUnderflow, outOverflow};
    exp = {eInPort, eInEmpty, eInReady, eOutData, eOutValid, eOutFull, eUnder, eOver};
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got In_Port=%h empty=%b rdy=%b outData=%h vld=%b full=%b und=%b ovf=%b, want In_Port=%h empty=%b rdy=%b outData=%h vld=%b full=%b und=%b ovf=%b",
               name, inPort, inEmpty, hostInReady, hostOutData, hostOutValid, outFull,
               inUnderflow, outOverflow, eInPort, eInEmpty, eInReady, eOutData, eOutValid,
               eOutFull, eUnder, eOver);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name,
                (mInQ.size() > 0) ? mInQ[0] : '0,
                mInQ.size() == 0,
                mInQ.size() < IN_DEPTH,
                (mOutQ.size() > 0) ? mOutQ[0] : '0,
                mOutQ.size() > 0,
                mOutQ.size() == OUT_DEPTH,
                mUnder, mOver);
  endtask

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic [DW-1:0] hd, input logic hv,
                      input logic rd, input logic [DW-1:0] op, input logic ow,
                      input logic hr, input logic clr);
    applyStimulus(rst, hd, hv, rd, op, ow, hr, clr);
    checkModel(name);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    mUnder       = 1'b0;
    mOver        = 1'b0;
    reset        = 1'b1;
    hostInData   = '0;
    hostInValid  = 1'b0;
    inRead       = 1'b0;
    outPort      = '0;
    outWrite     = 1'b0;
    hostOutReady = 1'b0;
    clearFlags   = 1'b0;

    // Directed vectors with hand-derived expectations. Field order:
    //        rst hd       hv rd op      ow hr clr | InPort   emp rdy outData  vld full und ovf
    vecs[0]  = '{1, 16'h0,    0, 0, 16'h0, 0, 0, 0,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};
    vecs[1]  = '{0, 16'h1111, 1, 0, 16'h0, 0, 0, 0,  16'h1111, 0, 1, 16'h0,    0, 0, 0, 0};
    vecs[2]  = '{0, 16'h2222, 1, 0, 16'h0, 0, 0, 0,  16'h1111, 0, 1, 16'h0,    0, 0, 0, 0};
    vecs[3]  = '{0, 16'h0,    0, 1, 16'h0, 0, 0, 0,  16'h2222, 0, 1, 16'h0,    0, 0, 0, 0};
    vecs[4]  = '{0, 16'h0,    0, 1, 16'h0, 0, 0, 0,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};
    vecs[5]  = '{0, 16'h0,    0, 1, 16'h0, 0, 0, 0,  16'h0,    1, 1, 16'h0,    0, 0, 1, 0};
    vecs[6]  = '{0, 16'h0,    0, 0, 16'h0, 0, 0, 1,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};
    vecs[7]  = '{0, 16'h0,    0, 1, 16'h0, 0, 0, 1,  16'h0,    1, 1, 16'h0,    0, 0, 1, 0};
    vecs[8]  = '{0, 16'h0,    0, 0, 16'h0, 0, 0, 1,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};
    vecs[9]  = '{0, 16'h0,    0, 0, 16'h5, 1, 0, 0,  16'h0,    1, 1, 16'h5,    1, 0, 0, 0};
    vecs[10] = '{0, 16'h0,    0, 0, 16'h6, 1, 0, 0,  16'h0,    1, 1, 16'h5,    1, 0, 0, 0};
    vecs[11] = '{0, 16'h0,    0, 0, 16'h0, 0, 1, 0,  16'h0,    1, 1, 16'h6,    1, 0, 0, 0};
    vecs[12] = '{0, 16'h0,    0, 0, 16'h0, 0, 1, 0,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};
    vecs[13] = '{0, 16'hAAAA, 1, 1, 16'h0, 0, 0, 0,  16'hAAAA, 0, 1, 16'h0,    0, 0, 1, 0};
    vecs[14] = '{0, 16'h0,    0, 1, 16'h0, 0, 0, 1,  16'h0,    1, 1, 16'h0,    0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hd, vecs[i].hv, vecs[i].rd, vecs[i].op,
                    vecs[i].ow, vecs[i].hr, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eInPort, vecs[i].eInEmpty,
                  vecs[i].eInReady, vecs[i].eOutData, vecs[i].eOutValid,
                  vecs[i].eOutFull, vecs[i].eUnder, vecs[i].eOver);
    end

    // Fill the input FIFO, then offer a fifth word that must be refused.
    for (int i = 0; i < 4; i++)
      step($sformatf("inFill%0d", i), 0, 16'hA000 + 16'(i), 1, 0, 0, 0, 0, 0);
    checkValue("inFullReady", {15'd0, hostInReady}, 16'd0);
    step("inHoldA004", 0, 16'hA004, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkValue($sformatf("inDrainHead%0d", i), inPort, 16'hA000 + 16'(i));
      step($sformatf("inDrain%0d", i), 0, 0, 0, 1, 0, 0, 0, 0);
    end
    checkValue("inDrainedZero", inPort, 16'h0);

    // Six words interleaved with pops, crossing the pointer wrap.
    for (int i = 0; i < 6; i++)
      step($sformatf("inWrap%0d", i), 0, 16'hC000 + 16'(i), 1, (i >= 2), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("inWrapDrain%0d", i), 0, 0, 0, 1, 0, 0, 0, 0);

    // Output overflow: fill, drop while not popping, then accept while popping.
    for (int i = 0; i < 4; i++)
      step($sformatf("outFill%0d", i), 0, 0, 0, 0, 16'h0B01 + 16'(i), 1, 0, 0);
    step("outDropBEEF", 0, 0, 0, 0, 16'hBEEF, 1, 0, 0);
    checkValue("outOverflowSet", {15'd0, outOverflow}, 16'd1);
    step("outAcceptCAFE", 0, 0, 0, 0, 16'hCAFE, 1, 1, 0);
    checkValue("outFullAfterCAFE", {15'd0, outFull}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) checkValue("outLastIsCAFE", hostOutData, 16'hCAFE);
      step($sformatf("outDrain%0d", i), 0, 0, 0, 0, 0, 0, 1, 0);
    end

    // Three words in each FIFO, then a mid-operation reset.
    for (int i = 0; i < 3; i++)
      step($sformatf("preRst%0d", i), 0, 16'hD000 + 16'(i), 1, 0, 16'hE000 + 16'(i), 1, 0, 0);
    step("rdEmptyPreRst", 0, 0, 0, 0, 0, 0, 0, 0);
    step("midReset", 1, 16'h1234, 1, 1, 16'h4321, 1, 1, 0);
    checkValue("rstInPort", inPort, 16'h0);
    step("pushAfterRst", 0, 16'h5555, 1, 0, 16'h6666, 1, 0, 0);
    checkValue("pushAfterRstIn", inPort, 16'h5555);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rand%0d", i),
           ($urandom_range(0, 59) == 0),
           16'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0),
           16'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Peripheral-side endpoint of the processor's 16-bit IN/OUT ports.
- Buffers host-supplied words in an input FIFO and presents the head word on In_Port. The processor pops that word when it executes IN.
- Captures every OUT write (Out_Port + strobe) into an output FIFO. The host drains it over a valid/ready interface.
- Instantiated beside Processor at top level.

Parameters:
DATA_W, 16, port data width
IN_DEPTH, 4, input FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; flushes both FIFOs and clears flags
host_in_data  input  DATA_W  word offered by host
host_in_valid  input  1  host word valid
host_in_ready  output  1  input FIFO can accept this cycle
In_Port  output  DATA_W  head of input FIFO; 0 when empty
in_read  input  1  one-cycle pulse from processor: IN executed, pop head
in_empty  output  1  input FIFO empty
Out_Port  input  DATA_W  processor OUT data
out_write  input  1  one-cycle pulse from processor: capture Out_Port
out_full  output  1  output FIFO full
host_out_data  output  DATA_W  head of output FIFO; 0 when empty
host_out_valid  output  1  output FIFO non-empty
host_out_ready  input  1  host consumes head this cycle
in_underflow  output  1  sticky: in_read while empty
out_overflow  output  1  sticky: out_write dropped while full
clear_flags  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset values:
  - Pointers and counts = 0.
  - In_Port = 0, host_out_data = 0.
  - host_in_ready = 1, in_empty = 1, host_out_valid = 0, out_full = 0.
  - in_underflow = 0, out_overflow = 0.
  - Reset overrides every other input in the same cycle. Mid-operation reset discards all buffered words.
- Each FIFO holds: storage array, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- All outputs derive combinationally from registered state only. There is no combinational path from any input to any output.
- Input FIFO:
  - host_in_ready = (in_count != IN_DEPTH).
  - Push when host_in_valid & host_in_ready.
  - Ready does not account for a same-cycle pop: the host never writes into a full FIFO even if a pop coincides.
  - Latency: a word pushed at edge N appears on In_Port after edge N if the FIFO was empty.
  - Pop when in_read & !in_empty; rd_ptr advances and In_Port shows the next word (or 0) after the edge.
  - in_read while empty: no state change except in_underflow <= 1; In_Port stays 0.
  - Push and pop in the same cycle with the FIFO non-empty: count unchanged, both pointers advance.
  - Push and in_read in the same cycle with the FIFO empty: push accepted, pop ignored, in_underflow set.
- Output FIFO:
  - Pop when host_out_valid & host_out_ready.
  - Push when out_write and (count < OUT_DEPTH or a pop occurs this cycle).
  - out_write while full with no same-cycle pop: word dropped, out_overflow <= 1.
  - out_write while full with a same-cycle pop: word accepted, no overflow, count stays OUT_DEPTH. This differs from the input side because the processor cannot stall on OUT.
  - out_full = (out_count == OUT_DEPTH).
- Sticky flags:
  - clear_flags clears both flags.
  - If a set event coincides with clear_flags, set wins: the flag reads 1 after the edge.
- Word order is strictly FIFO on both paths. Data is never modified.

Test Plan:
- Reset, then push 0x1111, 0x2222 via host_in_valid -> In_Port=0x1111 the cycle after the first push; in_read pulse -> In_Port=0x2222; second in_read -> In_Port=0, in_empty=1.
- Push 0xA000..0xA003 (IN_DEPTH=4) -> host_in_ready=0 after the 4th; hold valid with 0xA004 -> not accepted; pop four times -> In_Port sequence A000,A001,A002,A003, then 0. Wrap check: push 6 words interleaved with pops -> order preserved across the pointer wrap.
- in_read with the FIFO empty -> in_underflow=1, In_Port=0; clear_flags -> 0; clear_flags coincident with another empty in_read -> in_underflow=1.
- out_write with Out_Port=0x0005, 0x0006, host_out_ready=0 -> host_out_valid=1, host_out_data=0x0005; ready=1 for two cycles -> 0x0005, then 0x0006, then valid=0.
- Fill the output FIFO with 4 words, then out_write 0xBEEF with ready=0 -> dropped, out_overflow=1, count 4. Then out_write 0xCAFE with ready=1 -> accepted, count stays 4, 0xCAFE drains last, flag unchanged.
- With 3 words in each FIFO, assert reset for one cycle -> all counts 0, In_Port=0, host_out_valid=0, flags 0; a push the cycle after reset is accepted normally.
